// File: rtl/line_store_responder.sv
// line_store_responder
//   Memory-side responder for the lane-processing controller. Holds one
//   DEPTH x LINEW slice image, loads it line by line from the host, pulses
//   start once the image is complete, serves controller read/write requests
//   and, when the controller finishes, streams the image back to the host.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   in_valid/in_line/in_ready   host load stream
//   start                    one-cycle pulse: image loaded
//   readLine/rd_index        controller read request
//   line/line_valid          registered read data, valid one cycle later
//   writeVal/wr_index/wr_line   controller write request
//   finish                   controller done; begin draining
//   out_valid/out_line/out_ready   host drain stream (out_line = mem[ptr])
//   busy                     high in every state except IDLE
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | empty, waiting for the first load line (written to mem[0])
// LOAD  | accepting lines into mem[ptr] until line 63 arrives
// KICK  | single cycle, start = 1
// SERVE | controller reads/writes; finish moves to DRAIN
// DRAIN | streaming mem[ptr] to host; last handshake returns to IDLE

module line_store_responder #(
  parameter int LINEW = 25,
  parameter int DEPTH = 64,
  parameter int IDXW  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [LINEW-1:0] in_line,
  output logic             in_ready,
  output logic             start,
  input  logic             readLine,
  input  logic [IDXW-1:0]  rd_index,
  output logic [LINEW-1:0] line,
  output logic             line_valid,
  input  logic             writeVal,
  input  logic [IDXW-1:0]  wr_index,
  input  logic [LINEW-1:0] wr_line,
  input  logic             finish,
  output logic             out_valid,
  output logic [LINEW-1:0] out_line,
  input  logic             out_ready,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_KICK  = 3'd2,
    S_SERVE = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DEPTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDXW-1:0]  r_ptr;
  logic [IDXW-1:0]  w_ptr_nxt;
  logic [LINEW-1:0] r_mem [DEPTH];
  logic [LINEW-1:0] r_line;
  logic             r_line_valid;

  logic             w_we;
  logic [IDXW-1:0]  w_waddr;
  logic [LINEW-1:0] w_wdata;
  logic             w_rd_en;
  logic [LINEW-1:0] w_rd_data;

  // Next state, pointer, memory write port and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_we        = 1'b0;
    w_waddr     = r_ptr;
    w_wdata     = in_line;
    w_rd_en     = 1'b0;
    in_ready    = 1'b0;
    start       = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;

    unique case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          w_we        = 1'b1;
          w_waddr     = '0;
          w_ptr_nxt   = IDXW'(1);
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_we      = 1'b1;
          w_ptr_nxt = r_ptr + 1'b1;
          if (r_ptr == LAST_IDX) begin
            w_state_nxt = S_KICK;
          end
        end
      end
      S_KICK: begin
        start       = 1'b1;
        w_state_nxt = S_SERVE;
      end
      S_SERVE: begin
        w_rd_en = readLine;
        if (writeVal) begin
          w_we    = 1'b1;
          w_waddr = wr_index;
          w_wdata = wr_line;
        end
        if (finish) begin
          w_ptr_nxt   = '0;
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_ptr_nxt = r_ptr + 1'b1;
          if (r_ptr == LAST_IDX) begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_ptr_nxt   = '0;
      end
    endcase
  end

  // Same-index read during a write returns the data being written.
  assign w_rd_data = (w_we && (w_waddr == rd_index)) ? w_wdata : r_mem[rd_index];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  // line holds its last value whenever no read is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_line       <= '0;
      r_line_valid <= 1'b0;
    end else begin
      r_line_valid <= w_rd_en;
      if (w_rd_en) begin
        r_line <= w_rd_data;
      end
    end
  end

  assign line       = r_line;
  assign line_valid = r_line_valid;
  assign out_line   = r_mem[r_ptr];

endmodule

// File: tb/tb_line_store_responder.sv
// Directed bench for line_store_responder: load, serve, drain, reset mid-load.
module tb_line_store_responder;

  localparam int LINEW = 25;
  localparam int DEPTH = 64;
  localparam int IDXW  = 6;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic [LINEW-1:0] in_line;
  logic             in_ready;
  logic             start;
  logic             readLine;
  logic [IDXW-1:0]  rd_index;
  logic [LINEW-1:0] line;
  logic             line_valid;
  logic             writeVal;
  logic [IDXW-1:0]  wr_index;
  logic [LINEW-1:0] wr_line;
  logic             finish;
  logic             out_valid;
  logic [LINEW-1:0] out_line;
  logic             out_ready;
  logic             busy;

  int n_checks = 0;
  int n_errors = 0;

  line_store_responder #(.LINEW(LINEW), .DEPTH(DEPTH), .IDXW(IDXW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_line    (in_line),
    .in_ready   (in_ready),
    .start      (start),
    .readLine   (readLine),
    .rd_index   (rd_index),
    .line       (line),
    .line_valid (line_valid),
    .writeVal   (writeVal),
    .wr_index   (wr_index),
    .wr_line    (wr_line),
    .finish     (finish),
    .out_valid  (out_valid),
    .out_line   (out_line),
    .out_ready  (out_ready),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Loads n lines base+i; a one-cycle host gap is inserted before line gap_at.
  task automatic load_lines(input logic [LINEW-1:0] base, input int n, input int gap_at);
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin
        in_valid = 1'b0;
        tick();
        chk("gap_start", 32'(start), 32'd0);
        chk("gap_in_ready", 32'(in_ready), 32'd1);
      end
      in_valid = 1'b1;
      in_line  = base + LINEW'(i);
      tick();
      chk("load_busy", 32'(busy), 32'd1);
      chk("load_line_valid", 32'(line_valid), 32'd0);
      if (i == DEPTH - 1) chk("load_start_pulse", 32'(start), 32'd1);
      else                chk("load_start_low", 32'(start), 32'd0);
    end
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] exp_img(input int k);
    return (k == 7) ? 32'h1ABCDEF : 32'h1000 + 32'(k);
  endfunction

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_line = '0; readLine = 1'b0; rd_index = '0;
    writeVal = 1'b0; wr_index = '0; wr_line = '0; finish = 1'b0; out_ready = 1'b0;

    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'(start), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_line_valid", 32'(line_valid), 32'd0);
    chk("rst_line", 32'(line), 32'd0);
    chk("rst_out_line", 32'(out_line), 32'd0);
    rst = 1'b1;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);

    // Load with stray read/write/finish requests that must be ignored.
    readLine = 1'b1; rd_index = 6'd3; finish = 1'b1;
    writeVal = 1'b1; wr_index = 6'd9; wr_line = 25'h0;
    load_lines(25'h1000, 64, -1);
    readLine = 1'b0; finish = 1'b0; writeVal = 1'b0;
    chk("kick_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("serve_start_low", 32'(start), 32'd0);
    chk("serve_busy", 32'(busy), 32'd1);
    chk("serve_line_valid", 32'(line_valid), 32'd0);

    // Back-to-back reads.
    readLine = 1'b1; rd_index = 6'd5;  tick();
    chk("rd5_valid", 32'(line_valid), 32'd1);
    chk("rd5_line", 32'(line), 32'h1005);
    rd_index = 6'd6;  tick();
    chk("rd6_valid", 32'(line_valid), 32'd1);
    chk("rd6_line", 32'(line), 32'h1006);
    rd_index = 6'd63; tick();
    chk("rd63_valid", 32'(line_valid), 32'd1);
    chk("rd63_line", 32'(line), 32'h103F);
    readLine = 1'b0; tick();
    chk("rd_idle_valid", 32'(line_valid), 32'd0);
    chk("rd_idle_hold", 32'(line), 32'h103F);

    // Same-index write forwarding, then a plain read-back.
    writeVal = 1'b1; wr_index = 6'd7; wr_line = 25'h1ABCDEF;
    readLine = 1'b1; rd_index = 6'd7; tick();
    chk("fwd_line", 32'(line), 32'h1ABCDEF);
    writeVal = 1'b0; tick();
    chk("rd7_after_wr", 32'(line), 32'h1ABCDEF);
    // Different-index write and read in the same cycle.
    writeVal = 1'b1; wr_index = 6'd8; wr_line = 25'h1008;
    rd_index = 6'd10; tick();
    chk("diff_idx_line", 32'(line), 32'h100A);
    writeVal = 1'b0;

    // finish with a read in the same cycle.
    finish = 1'b1; rd_index = 6'd0; tick();
    chk("fin_out_valid", 32'(out_valid), 32'd1);
    chk("fin_line_valid", 32'(line_valid), 32'd1);
    chk("fin_line", 32'(line), 32'h1000);
    chk("fin_out_line", 32'(out_line), 32'h1000);

    // Requests in DRAIN are ignored; host stalls.
    out_ready = 1'b0; tick();
    chk("drain_no_line_valid", 32'(line_valid), 32'd0);
    chk("drain_stay", 32'(out_valid), 32'd1);
    chk("drain_hold_ptr", 32'(out_line), 32'h1000);
    readLine = 1'b0; finish = 1'b0;

    for (int k = 0; k < DEPTH; k++) begin
      out_ready = 1'b0;
      tick();
      chk("drain_valid", 32'(out_valid), 32'd1);
      chk("drain_stall_line", 32'(out_line), exp_img(k));
      out_ready = 1'b1;
      chk("drain_line", 32'(out_line), exp_img(k));
      tick();
    end
    out_ready = 1'b0;
    chk("post_drain_busy", 32'(busy), 32'd0);
    chk("post_drain_out_valid", 32'(out_valid), 32'd0);
    chk("post_drain_in_ready", 32'(in_ready), 32'd1);
    chk("post_drain_line_valid", 32'(line_valid), 32'd0);

    // Reset mid-load, then a full reload with a host gap.
    load_lines(25'h2000, 30, -1);
    rst = 1'b0; #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_line", 32'(out_line), 32'd0);
    tick();
    rst = 1'b1;
    load_lines(25'h3000, 64, 32);
    tick();
    chk("reload_serve_start", 32'(start), 32'd0);
    readLine = 1'b1; rd_index = 6'd0; tick();
    chk("reload_rd0", 32'(line), 32'h3000);
    rd_index = 6'd29; tick();
    chk("reload_rd29", 32'(line), 32'h301D);
    readLine = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
